// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: radix-2 restoring divide sequencer for Ex, stalling the pipeline until {remainder, quotient} is ready.
module ex_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);
  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;
  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [DATA_W-1:0]   mag1, mag2, quo, rmd;
  logic [DATA_W:0]     shf, trial;
  logic                sign1, sign2, negq_q, negq_d, negr_q, negr_d, ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  assign sign1 = signed_i & opdata1_i[DATA_W-1];
  assign sign2 = signed_i & opdata2_i[DATA_W-1];
  assign mag1  = sign1 ? -opdata1_i : opdata1_i;
  assign mag2  = sign2 ? -opdata2_i : opdata2_i;
  // The partial remainder never exceeds the divisor, so its 33rd bit only lives in the trial.
  assign shf   = {rem_q, dvd_q[DATA_W-1]};
  assign trial = shf - {1'b0, dvs_q};
  assign quo   = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
  assign rmd   = trial[DATA_W] ? shf[DATA_W-1:0] : trial[DATA_W-1:0];
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    ready_d    = 1'b0;
    result_d   = '0;
    stallreq_o = 1'b0;
    if (annul_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          stallreq_o = 1'b1;
          if (opdata2_i == '0) begin
            state_d = DIVZERO;
            dvd_d   = opdata1_i;
          end else begin
            state_d = BUSY;
            dvd_d   = mag1;
            dvs_d   = mag2;
            negq_d  = sign1 ^ sign2;
            negr_d  = sign1;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
        DIVZERO: begin
          stallreq_o = 1'b1;
          state_d    = DONE;
          ready_d    = 1'b1;
          result_d   = {dvd_q, {DATA_W{1'b1}}};
        end
        BUSY: begin
          stallreq_o = 1'b1;
          rem_d      = rmd;
          dvd_d      = quo;
          cnt_d      = cnt_q + 6'd1;
          if (cnt_q == 6'(DATA_W-1)) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {negr_q ? -rmd : rmd, negq_q ? -quo : quo};
          end
        end
        DONE: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end
  assign ready_o  = ready_q;
  assign result_o = result_q;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: table-driven divide vectors plus annul, reset and back-to-back sequences.
module tb_ex_div_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
  int          checks = 0;
  int          failures = 0;
  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;
  vec_t vecs[12];
  ex_div_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Issue a request at the next negedge and follow it to ready_o; start_i is left high.
  task automatic div(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] er, input int lat);
    int n;
    logic stall_ok;
    @(negedge clk);
    start_i = 1'b1; signed_i = sg; opdata1_i = a; opdata2_i = b;
    #1 chk({name, " stall_req"}, 64'(stallreq_o), 64'd1);
    n = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      #1 n++;
      if (!ready_o && !stallreq_o) stall_ok = 1'b0;
    end while (!ready_o && n < 100);
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, result_o, er);
    chk({name, " stall_done"}, 64'(stallreq_o), 64'd0);
    chk({name, " stall_busy"}, 64'(stall_ok), 64'd1);
  endtask
  task automatic ready_gone(input string name);
    @(negedge clk);
    #1 chk({name, " ready_width"}, 64'(ready_o), 64'd0);
    chk({name, " result_idle"}, result_o, 64'd0);
  endtask
  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'h00000001, 32'h7FFFFFFC},    33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},           33};
    vecs[4]  = '{1'b0, 32'd0,          32'd5,          64'd0,                           33};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF},           33};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h1, 32'hFFFFFFFD},           33};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'h3},           33};
    vecs[8]  = '{1'b0, 32'd5,          32'd0,          {32'h5, 32'hFFFFFFFF},           2};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          {32'hFFFFFFF9, 32'hFFFFFFFF},    2};
    vecs[10] = '{1'b0, 32'd9,          32'd3,          {32'h0, 32'h3},                  33};
    vecs[11] = '{1'b0, 32'd7,          32'd9,          {32'h7, 32'h0},                  33};
    repeat (3) @(negedge clk);
    #1 chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset stall", 64'(stallreq_o), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      div($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      start_i = 1'b0;
      ready_gone($sformatf("vec%0d", i));
    end
    // Annul at T+10 while start_i is still held.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1 chk("annul stall_drop", 64'(stallreq_o), 64'd0);
    chk("annul no_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    #1 chk("annul idle_stall", 64'(stallreq_o), 64'd0);
    chk("annul idle_ready", 64'(ready_o), 64'd0);
    chk("annul idle_result", result_o, 64'd0);
    div("post_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    start_i = 1'b0;
    ready_gone("post_annul");
    // Synchronous reset at T+20.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'hFFFFFFF9; opdata2_i = 32'd2;
    repeat (20) @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    #1 chk("rst_mid stall", 64'(stallreq_o), 64'd0);
    chk("rst_mid ready", 64'(ready_o), 64'd0);
    chk("rst_mid result", result_o, 64'd0);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    #1 chk("rst_mid no_late_ready", 64'(ready_o), 64'd0);
    div("post_rst", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    start_i = 1'b0;
    ready_gone("post_rst");
    // Back-to-back with start_i held through DONE.
    div("b2b_first", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    div("b2b_second", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    start_i = 1'b0;
    ready_gone("b2b_second");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
